// File: rtl/cache_refill_controller_if.sv
// rtl/cache_refill_controller_if.sv - memory beat request/response bus for the refill controller
interface cache_refill_controller_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/cache_refill_controller.sv
// rtl/cache_refill_controller.sv - single-MSHR line refill with store merge and load wakeup (option: REFILL_EARLY_WAKEUP_EN)
module cache_refill_controller #(
  parameter int LINE_WORDS  = 4,
  parameter int ROB_ENTRIES = 16,
  parameter int ROB_IDX_W   = $clog2(ROB_ENTRIES)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 repair_req_i,
  input  logic [31:0]          repair_addr_i,
  input  logic [31:0]          repair_data_i,
  input  logic [ROB_IDX_W-1:0] repair_rob_idx_i,
  input  logic                 repair_is_store_i,
  output logic                 repair_ack_o,
  output logic                 repair_complete_o,
  cache_refill_controller_if.master mem,
  output logic                 cache_wr_en_o,
  output logic [31:0]          cache_wr_addr_o,
  output logic [31:0]          cache_wr_data_o,
  output logic                 cache_tag_wr_o,
  output logic [31:0]          cache_tag_addr_o,
  output logic                 cache_tag_dirty_o,
  output logic                 ld_wb_valid_o,
  output logic [ROB_IDX_W-1:0] ld_wb_rob_idx_o,
  output logic [31:0]          ld_wb_data_o
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [31:0]      LINE_MASK = ~(32'(4 * LINE_WORDS) - 32'd1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_INSTALL} state_e;

  state_e                state_q;
  logic [31:0]           addr_q;
  logic [31:0]           data_q;
  logic [ROB_IDX_W-1:0]  rob_q;
  logic                  is_store_q;
  logic                  kill_q;
  logic [CNT_W-1:0]      issue_cnt_q;
  logic [CNT_W-1:0]      resp_cnt_q;
`ifndef REFILL_EARLY_WAKEUP_EN
  logic [31:0]           ld_data_q;
`endif

  logic [31:0]      line_base;
  logic [OFF_W-1:0] req_off;
  logic             mem_req;
  logic             beat_take;
  logic             resp_fire;
  logic             resp_hit;
  logic             resp_last;
  logic             wb_valid;

  assign line_base = addr_q & LINE_MASK;
  assign req_off   = addr_q[OFF_W+1:2];
  assign mem_req   = (state_q == S_FILL) && (issue_cnt_q < CNT_FULL);
  assign beat_take = mem_req && mem.gnt;
  assign resp_fire = (state_q == S_FILL) && mem.rvalid;
  assign resp_hit  = resp_fire && (resp_cnt_q[OFF_W-1:0] == req_off);
  assign resp_last = resp_fire && (resp_cnt_q == CNT_LAST);

  // Request side: keep asking until every beat of the line has been granted
  assign repair_ack_o = (state_q == S_IDLE) && repair_req_i;
  assign mem.req      = mem_req;
  assign mem.addr     = mem_req ? (line_base + (32'(issue_cnt_q) << 2)) : 32'd0;

  // Fill port: the requested word of a store miss takes the store data instead of memory
  assign cache_wr_en_o   = resp_fire;
  assign cache_wr_addr_o = resp_fire ? (line_base + (32'(resp_cnt_q) << 2)) : 32'd0;
  assign cache_wr_data_o = !resp_fire ? 32'd0 : ((resp_hit && is_store_q) ? data_q : mem.rdata);

  assign cache_tag_wr_o    = (state_q == S_INSTALL);
  assign cache_tag_addr_o  = cache_tag_wr_o ? line_base : 32'd0;
  assign cache_tag_dirty_o = cache_tag_wr_o && is_store_q;
  assign repair_complete_o = cache_tag_wr_o;

  // Load wakeup: a flush in the same cycle also suppresses the pulse
`ifdef REFILL_EARLY_WAKEUP_EN
  assign wb_valid     = resp_hit && !is_store_q && !kill_q && !flush_i;
  assign ld_wb_data_o = wb_valid ? mem.rdata : 32'd0;
`else
  assign wb_valid     = cache_tag_wr_o && !is_store_q && !kill_q && !flush_i;
  assign ld_wb_data_o = wb_valid ? ld_data_q : 32'd0;
`endif
  assign ld_wb_valid_o   = wb_valid;
  assign ld_wb_rob_idx_o = wb_valid ? rob_q : '0;

  // Refill FSM with request capture, beat counters and kill tracking
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      rob_q       <= '0;
      is_store_q  <= 1'b0;
      kill_q      <= 1'b0;
      issue_cnt_q <= '0;
      resp_cnt_q  <= '0;
`ifndef REFILL_EARLY_WAKEUP_EN
      ld_data_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (repair_req_i) begin
            addr_q      <= repair_addr_i;
            data_q      <= repair_data_i;
            rob_q       <= repair_rob_idx_i;
            is_store_q  <= repair_is_store_i;
            kill_q      <= flush_i;
            issue_cnt_q <= '0;
            resp_cnt_q  <= '0;
            state_q     <= S_FILL;
          end
        end
        S_FILL: begin
          if (beat_take) issue_cnt_q <= issue_cnt_q + 1'b1;
          if (resp_fire) resp_cnt_q <= resp_cnt_q + 1'b1;
          if (flush_i) kill_q <= 1'b1;
`ifndef REFILL_EARLY_WAKEUP_EN
          if (resp_hit) ld_data_q <= mem.rdata;
`endif
          if (resp_last) state_q <= S_INSTALL;
        end
        S_INSTALL: begin
          if (flush_i) kill_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_controller.sv
// tb/tb_cache_refill_controller.sv - directed self-checking bench for cache_refill_controller
module tb_cache_refill_controller;
  localparam int LW  = 4;
  localparam int RIW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush, req, is_store;
  logic [31:0]    raddr, sdata;
  logic [RIW-1:0] rob;
  logic           ack_o, cmpl_o, wr_en_o, tag_wr_o, dirty_o, ldwb_v_o;
  logic [31:0]    wr_addr_o, wr_data_o, tag_addr_o, ldwb_data_o;
  logic [RIW-1:0] ldwb_rob_o;

  cache_refill_controller_if mem_if ();

  cache_refill_controller #(.LINE_WORDS(LW), .ROB_ENTRIES(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .repair_req_i(req), .repair_addr_i(raddr), .repair_data_i(sdata),
    .repair_rob_idx_i(rob), .repair_is_store_i(is_store),
    .repair_ack_o(ack_o), .repair_complete_o(cmpl_o), .mem(mem_if),
    .cache_wr_en_o(wr_en_o), .cache_wr_addr_o(wr_addr_o), .cache_wr_data_o(wr_data_o),
    .cache_tag_wr_o(tag_wr_o), .cache_tag_addr_o(tag_addr_o), .cache_tag_dirty_o(dirty_o),
    .ld_wb_valid_o(ldwb_v_o), .ld_wb_rob_idx_o(ldwb_rob_o), .ld_wb_data_o(ldwb_data_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] pat = 32'h0;
  int          lat = 1;
  bit          stall_en = 1'b0;
  int          stall = 0;

  int          ack_log[$];
  logic [31:0] gnt_log[$];
  logic [31:0] wa_log[$];
  logic [31:0] wd_log[$];
  int          wc_log[$];
  logic [31:0] q_addr[$];
  int          q_due[$];
  int          tag_n = 0, cmpl_n = 0, ldwb_n = 0;
  int          cmpl_cyc = 0, ldwb_cyc = 0, last_rv_cyc = 0;
  logic [31:0] tag_addr_l = 0, ldwb_data_l = 0;
  logic        tag_dirty_l = 0;
  logic [RIW-1:0] ldwb_rob_l = 0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Memory model and monitor: sample on the falling edge, drive just after the rising edge
  initial begin
    mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ack_o) ack_log.push_back(cyc);
        if (mem_if.req && mem_if.gnt) begin
          gnt_log.push_back(mem_if.addr);
          q_addr.push_back(mem_if.addr);
          q_due.push_back(cyc + lat);
          if (stall_en) stall = $urandom_range(0, 3);
        end
        if (mem_if.rvalid) begin
          last_rv_cyc = cyc;
          void'(q_addr.pop_front());
          void'(q_due.pop_front());
        end
        if (wr_en_o) begin
          wa_log.push_back(wr_addr_o); wd_log.push_back(wr_data_o); wc_log.push_back(cyc);
        end
        if (tag_wr_o) begin tag_n++; tag_addr_l = tag_addr_o; tag_dirty_l = dirty_o; end
        if (cmpl_o) begin cmpl_n++; cmpl_cyc = cyc; end
        if (ldwb_v_o) begin
          ldwb_n++; ldwb_cyc = cyc; ldwb_data_l = ldwb_data_o; ldwb_rob_l = ldwb_rob_o;
        end
      end
      @(posedge clk); #1;
      if (!rst_n) begin
        q_addr.delete(); q_due.delete(); stall = 0;
        mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = 32'd0;
      end else begin
        if (stall > 0) begin mem_if.gnt = 1'b0; stall--; end
        else mem_if.gnt = 1'b1;
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
          mem_if.rvalid = 1'b1;
          mem_if.rdata  = pat + ((q_addr[0] >> 2) & 32'(LW - 1));
        end else begin
          mem_if.rvalid = 1'b0;
          mem_if.rdata  = 32'd0;
        end
      end
    end
  end

  task automatic check_all_zero(input string p);
    check({p, "_mem_req"}, 32'(mem_if.req), 0);
    check({p, "_mem_addr"}, mem_if.addr, 0);
    check({p, "_wr_en"}, 32'(wr_en_o), 0);
    check({p, "_wr_addr"}, wr_addr_o, 0);
    check({p, "_wr_data"}, wr_data_o, 0);
    check({p, "_tag_wr"}, 32'(tag_wr_o), 0);
    check({p, "_tag_addr"}, tag_addr_o, 0);
    check({p, "_dirty"}, 32'(dirty_o), 0);
    check({p, "_cmpl"}, 32'(cmpl_o), 0);
    check({p, "_ldwb_v"}, 32'(ldwb_v_o), 0);
    check({p, "_ldwb_rob"}, 32'(ldwb_rob_o), 0);
    check({p, "_ldwb_data"}, ldwb_data_o, 0);
    check({p, "_ack"}, 32'(ack_o), 0);
  endtask

  task automatic run_refill(input logic [31:0] a, input logic [31:0] d, input logic [RIW-1:0] rb,
                            input logic st, input int flush_at, output int t_ack);
    int c0;
    c0 = cmpl_n;
    raddr = a; sdata = d; rob = rb; is_store = st; req = 1'b1;
    @(negedge clk);
    check("ack", 32'(ack_o), 1);
    t_ack = cyc;
    @(posedge clk); #1;
    req = 1'b0;
    for (int i = 0; i < 200 && cmpl_n == c0; i++) begin
      flush = (i == flush_at);
      @(posedge clk); #1;
    end
    flush = 1'b0;
    check("complete_pulses", 32'(cmpl_n - c0), 1);
  endtask

  task automatic check_line(input string p, input int g0, input int w0, input logic [31:0] a,
                            input logic [31:0] d, input logic st);
    logic [31:0] base;
    int          off;
    base = a & ~32'(4 * LW - 1);
    off  = int'((a >> 2) & 32'(LW - 1));
    check({p, "_nbeats"}, 32'(wa_log.size() - w0), LW);
    check({p, "_ngrants"}, 32'(gnt_log.size() - g0), LW);
    if (wa_log.size() >= w0 + LW && gnt_log.size() >= g0 + LW) begin
      for (int i = 0; i < LW; i++) begin
        check($sformatf("%s_gnt_addr%0d", p, i), gnt_log[g0 + i], base + 32'(4 * i));
        check($sformatf("%s_wr_addr%0d", p, i), wa_log[w0 + i], base + 32'(4 * i));
        check($sformatf("%s_wr_data%0d", p, i), wd_log[w0 + i],
              (st && i == off) ? d : pat + 32'(i));
      end
    end
  endtask

  task automatic check_wake(input string p, input int w0, input int off);
`ifdef REFILL_EARLY_WAKEUP_EN
    if (wc_log.size() > w0 + off) check({p, "_wake_cyc"}, 32'(ldwb_cyc), 32'(wc_log[w0 + off]));
    else check({p, "_wake_beat_missing"}, 32'(wc_log.size()), 32'(w0 + off + 1));
`else
    check({p, "_wake_cyc"}, 32'(ldwb_cyc), 32'(cmpl_cyc));
    if (off < 0) check({p, "_unused"}, 32'(w0), 32'(w0 + 1));
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, g0, w0, l0, t0, c0, a0;
    rst_n = 1'b0; flush = 1'b0; req = 1'b0; raddr = 0; sdata = 0; rob = 0; is_store = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Load miss, zero-wait memory, latency 1
    pat = 32'hA0; lat = 1; stall_en = 1'b0;
    g0 = gnt_log.size(); w0 = wa_log.size(); l0 = ldwb_n; t0 = tag_n;
    run_refill(32'h0000_1048, 32'h0, 4'd5, 1'b0, -1, t);
    check_line("t1", g0, w0, 32'h1048, 32'h0, 1'b0);
    check("t1_ldwb_n", 32'(ldwb_n - l0), 1);
    check("t1_ldwb_data", ldwb_data_l, 32'hA2);
    check("t1_ldwb_rob", 32'(ldwb_rob_l), 5);
    check("t1_tag_n", 32'(tag_n - t0), 1);
    check("t1_tag_addr", tag_addr_l, 32'h1040);
    check("t1_dirty", 32'(tag_dirty_l), 0);
    check("t1_latency", 32'(cmpl_cyc - t), 32'(LW + 1 + 1));
    check_wake("t1", w0, 2);

    // Store miss with merge
    pat = 32'hB0;
    g0 = gnt_log.size(); w0 = wa_log.size(); l0 = ldwb_n; t0 = tag_n;
    run_refill(32'h0000_2004, 32'hDEAD_BEEF, 4'd7, 1'b1, -1, t);
    check_line("t2", g0, w0, 32'h2004, 32'hDEAD_BEEF, 1'b1);
    check("t2_ldwb_n", 32'(ldwb_n - l0), 0);
    check("t2_tag_addr", tag_addr_l, 32'h2000);
    check("t2_dirty", 32'(tag_dirty_l), 1);

    // Flush during FILL of a load
    pat = 32'hC0;
    g0 = gnt_log.size(); w0 = wa_log.size(); l0 = ldwb_n; t0 = tag_n;
    run_refill(32'h0000_300C, 32'h0, 4'd9, 1'b0, 2, t);
    check_line("t3", g0, w0, 32'h300C, 32'h0, 1'b0);
    check("t3_ldwb_n", 32'(ldwb_n - l0), 0);
    check("t3_tag_n", 32'(tag_n - t0), 1);
    check("t3_tag_addr", tag_addr_l, 32'h3000);

    // Second request held through a refill
    pat = 32'h40;
    a0 = ack_log.size(); c0 = cmpl_n;
    raddr = 32'h0000_4000; sdata = 0; rob = 4'd1; is_store = 1'b0; req = 1'b1;
    for (int i = 0; i < 100 && ack_log.size() < a0 + 2; i++) begin
      @(posedge clk); #1;
    end
    req = 1'b0;
    check("t4_acks", 32'(ack_log.size() - a0), 2);
    check("t4_cmpl_between", 32'(cmpl_n - c0), 1);
    if (ack_log.size() >= a0 + 2) check("t4_reack_cyc", 32'(ack_log[a0 + 1]), 32'(cmpl_cyc + 1));
    for (int i = 0; i < 100 && cmpl_n < c0 + 2; i++) begin
      @(posedge clk); #1;
    end
    check("t4_second_cmpl", 32'(cmpl_n - c0), 2);

    // Random grant stalls, response latency 3
    pat = 32'hD0; lat = 3; stall_en = 1'b1;
    g0 = gnt_log.size(); w0 = wa_log.size(); l0 = ldwb_n;
    run_refill(32'h0000_5014, 32'h0, 4'd3, 1'b0, -1, t);
    check_line("t5", g0, w0, 32'h5014, 32'h0, 1'b0);
    check("t5_cmpl_after_rv", 32'(cmpl_cyc), 32'(last_rv_cyc + 1));
    check("t5_ldwb_n", 32'(ldwb_n - l0), 1);
    check("t5_ldwb_data", ldwb_data_l, 32'hD1);
    check_wake("t5", w0, 1);
    stall_en = 1'b0; lat = 1;
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of FILL
    pat = 32'h60;
    t0 = tag_n; c0 = cmpl_n;
    raddr = 32'h0000_6000; rob = 4'd2; is_store = 1'b0; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check("t6_in_fill_req", 32'(mem_if.req), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("t6_no_install", 32'(tag_n - t0), 0);
    check("t6_no_cmpl", 32'(cmpl_n - c0), 0);

    // Normal refill after reset, last word of line, top ROB index
    pat = 32'h70;
    g0 = gnt_log.size(); w0 = wa_log.size(); l0 = ldwb_n;
    run_refill(32'h0000_7FFC, 32'h0, 4'd15, 1'b0, -1, t);
    check_line("t7", g0, w0, 32'h7FFC, 32'h0, 1'b0);
    check("t7_ldwb_data", ldwb_data_l, 32'h73);
    check("t7_ldwb_rob", 32'(ldwb_rob_l), 15);
    check("t7_tag_addr", tag_addr_l, 32'h7FF0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
